rtc_bus_responder: RTL and testbench

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

---
 rtl/rtc_bus_responder.sv | 191 +++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_responder.sv
// Bus-mapped BCD real-time clock and calendar, with a countdown timer that raises an interrupt.
// Writes commit on the WR rising edge. Reads come back one cycle later through a registered mux.
module rtc_bus_responder #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic       AD,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       irq
);

  localparam int PW = $clog2(TICKS_PER_SEC);

  logic          r_wr_d, r_cs_d, r_ad_d;
  logic [7:0]    r_din_d;
  logic [7:0]    r_addr;
  logic [PW-1:0] r_presc;
  logic          r_tick_pend;
  logic [7:0]    r_sec, r_min, r_hour, r_day, r_month, r_year;
  logic [7:0]    r_tsec, r_tmin, r_thour;
  logic          r_timer_en, r_irq_flag;
  logic [7:0]    r_data_out;
  logic          r_data_oe;

  logic       w_commit, w_addr_commit, w_data_commit;
  logic       w_tick_raw, w_tick_req;
  logic [7:0] w_dim;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_month_wrap;
  logic [7:0] w_sec_nxt, w_min_nxt, w_hour_nxt, w_day_nxt, w_month_nxt, w_year_nxt;
  logic       w_timer_zero, w_dec_zero;
  logic [7:0] w_tsec_dec, w_tmin_dec, w_thour_dec;
  logic [7:0] w_rd_val;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_commit      = ~r_wr_d & WR & ~r_cs_d;
  assign w_addr_commit = w_commit & ~r_ad_d;
  assign w_data_commit = w_commit & r_ad_d;

  // A tick that lands on a data commit is held for one cycle, so the write never races the carry chain.
  assign w_tick_raw = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_tick_req = w_tick_raw | r_tick_pend;

  always_comb begin
    case (r_month)
      8'h02:                      w_dim = 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: w_dim = 8'h30;
      default:                    w_dim = 8'h31;
    endcase
    w_sec_wrap   = (r_sec >= 8'h59);
    w_min_wrap   = (r_min >= 8'h59);
    w_hour_wrap  = (r_hour >= 8'h23);
    w_day_wrap   = (r_day >= w_dim);
    w_month_wrap = (r_month >= 8'h12);
    w_sec_nxt    = w_sec_wrap   ? 8'h00 : bcd_inc(r_sec);
    w_min_nxt    = w_min_wrap   ? 8'h00 : bcd_inc(r_min);
    w_hour_nxt   = w_hour_wrap  ? 8'h00 : bcd_inc(r_hour);
    w_day_nxt    = w_day_wrap   ? 8'h01 : bcd_inc(r_day);
    w_month_nxt  = w_month_wrap ? 8'h01 : bcd_inc(r_month);
    w_year_nxt   = (r_year >= 8'h99) ? 8'h00 : bcd_inc(r_year);
  end

  always_comb begin
    w_timer_zero = (r_tsec == 8'h00) && (r_tmin == 8'h00) && (r_thour == 8'h00);
    w_tsec_dec   = (r_tsec == 8'h00) ? 8'h59 : bcd_dec(r_tsec);
    w_tmin_dec   = r_tmin;
    w_thour_dec  = r_thour;
    if (r_tsec == 8'h00) begin
      w_tmin_dec = (r_tmin == 8'h00) ? 8'h59 : bcd_dec(r_tmin);
      if (r_tmin == 8'h00) w_thour_dec = bcd_dec(r_thour);
    end
    w_dec_zero = (w_tsec_dec == 8'h00) && (w_tmin_dec == 8'h00) && (w_thour_dec == 8'h00);
  end

  always_comb begin
    case (r_addr)
      8'h00:   w_rd_val = {6'd0, r_irq_flag, r_timer_en};
      8'h21:   w_rd_val = r_sec;
      8'h22:   w_rd_val = r_min;
      8'h23:   w_rd_val = r_hour;
      8'h24:   w_rd_val = r_day;
      8'h25:   w_rd_val = r_month;
      8'h26:   w_rd_val = r_year;
      8'h41:   w_rd_val = r_tsec;
      8'h42:   w_rd_val = r_tmin;
      8'h43:   w_rd_val = r_thour;
      default: w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_d      <= 1'b1;
      r_cs_d      <= 1'b1;
      r_ad_d      <= 1'b0;
      r_din_d     <= 8'h00;
      r_addr      <= 8'h00;
      r_presc     <= '0;
      r_tick_pend <= 1'b0;
      r_sec       <= 8'h00;
      r_min       <= 8'h00;
      r_hour      <= 8'h00;
      r_day       <= 8'h01;
      r_month     <= 8'h01;
      r_year      <= 8'h00;
      r_tsec      <= 8'h00;
      r_tmin      <= 8'h00;
      r_thour     <= 8'h00;
      r_timer_en  <= 1'b0;
      r_irq_flag  <= 1'b0;
      r_data_out  <= 8'h00;
      r_data_oe   <= 1'b0;
    end else begin
      r_wr_d      <= WR;
      r_cs_d      <= CS;
      r_ad_d      <= AD;
      r_din_d     <= data_in;
      r_presc     <= w_tick_raw ? '0 : r_presc + PW'(1);
      r_tick_pend <= w_tick_req & w_data_commit;
      r_data_out  <= w_rd_val;
      r_data_oe   <= ~CS & AD & ~RD & WR;
      if (w_addr_commit) r_addr <= r_din_d;
      if (w_data_commit) begin
        case (r_addr)
          8'h00: begin
            r_timer_en <= r_din_d[0];
            if (!r_din_d[1]) r_irq_flag <= 1'b0;
          end
          8'h21:   r_sec   <= r_din_d;
          8'h22:   r_min   <= r_din_d;
          8'h23:   r_hour  <= r_din_d;
          8'h24:   r_day   <= r_din_d;
          8'h25:   r_month <= r_din_d;
          8'h26:   r_year  <= r_din_d;
          8'h41:   r_tsec  <= r_din_d;
          8'h42:   r_tmin  <= r_din_d;
          8'h43:   r_thour <= r_din_d;
          default: ;
        endcase
      end else if (w_tick_req) begin
        r_sec <= w_sec_nxt;
        if (w_sec_wrap) begin
          r_min <= w_min_nxt;
          if (w_min_wrap) begin
            r_hour <= w_hour_nxt;
            if (w_hour_wrap) begin
              r_day <= w_day_nxt;
              if (w_day_wrap) begin
                r_month <= w_month_nxt;
                if (w_month_wrap) r_year <= w_year_nxt;
              end
            end
          end
        end
        if (r_timer_en) begin
          if (w_timer_zero) begin
            r_irq_flag <= 1'b1;
            r_timer_en <= 1'b0;
          end else begin
            r_tsec  <= w_tsec_dec;
            r_tmin  <= w_tmin_dec;
            r_thour <= w_thour_dec;
            if (w_dec_zero) begin
              r_irq_flag <= 1'b1;
              r_timer_en <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign irq      = ~r_irq_flag;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed register scenarios followed by a random bus mix.
// A cycle-level behavioural model checks every output on every cycle.
module tb_rtc_bus_responder;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CS = 1'b1, AD = 1'b0, RD = 1'b1, WR = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, irq;

  always #5 clk = ~clk;

  rtc_bus_responder #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .CS(CS), .AD(AD), .RD(RD), .WR(WR),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: calendar as BCD bytes stepped by integer arithmetic, timer as plain integers
  bit         m_live = 0;
  int         m_cnt;
  bit         m_pend;
  logic       m_wr_d, m_cs_d, m_ad_d;
  logic [7:0] m_din_d, m_addr;
  logic [7:0] m_cal [6];
  int         m_th, m_tm, m_ts;
  bit         m_en, m_flag;
  logic [7:0] m_dout;
  logic       m_oe;

  function automatic logic [7:0] b2d(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic int d2b(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] mx,
                                      input logic [7:0] mn, output bit wrapped);
    wrapped = (v >= mx);
    return wrapped ? mn : b2d(d2b(v) + 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {6'd0, m_flag, m_en};
      8'h21: return m_cal[0];
      8'h22: return m_cal[1];
      8'h23: return m_cal[2];
      8'h24: return m_cal[3];
      8'h25: return m_cal[4];
      8'h26: return m_cal[5];
      8'h41: return b2d(m_ts);
      8'h42: return b2d(m_tm);
      8'h43: return b2d(m_th);
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] v);
    case (a)
      8'h00: begin m_en = v[0]; if (!v[1]) m_flag = 0; end
      8'h21: m_cal[0] = v;
      8'h22: m_cal[1] = v;
      8'h23: m_cal[2] = v;
      8'h24: m_cal[3] = v;
      8'h25: m_cal[4] = v;
      8'h26: m_cal[5] = v;
      8'h41: m_ts = d2b(v);
      8'h42: m_tm = d2b(v);
      8'h43: m_th = d2b(v);
      default: ;
    endcase
  endtask

  task automatic m_tick();
    logic [7:0] mx [6];
    logic [7:0] mn [6];
    bit w;
    int tot;
    mx[0] = 8'h59; mx[1] = 8'h59; mx[2] = 8'h23; mx[4] = 8'h12; mx[5] = 8'h99;
    case (m_cal[4])
      8'h02:                      mx[3] = 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: mx[3] = 8'h30;
      default:                    mx[3] = 8'h31;
    endcase
    mn[0] = 8'h00; mn[1] = 8'h00; mn[2] = 8'h00; mn[3] = 8'h01; mn[4] = 8'h01; mn[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      m_cal[i] = step(m_cal[i], mx[i], mn[i], w);
      if (!w) break;
    end
    if (m_en) begin
      tot = m_th * 3600 + m_tm * 60 + m_ts;
      if (tot > 0) begin
        tot--;
        m_th = tot / 3600; m_tm = (tot / 60) % 60; m_ts = tot % 60;
      end
      if (tot == 0) begin m_flag = 1; m_en = 0; end
    end
  endtask

  always @(posedge clk) begin
    bit commit, dcommit, raw, req;
    logic [7:0] nx_dout;
    logic nx_oe;
    if (reset) begin
      m_live = 1; m_cnt = 0; m_pend = 0;
      m_wr_d = 1; m_cs_d = 1; m_ad_d = 0; m_din_d = 0; m_addr = 0;
      m_cal[0] = 8'h00; m_cal[1] = 8'h00; m_cal[2] = 8'h00;
      m_cal[3] = 8'h01; m_cal[4] = 8'h01; m_cal[5] = 8'h00;
      m_th = 0; m_tm = 0; m_ts = 0; m_en = 0; m_flag = 0;
      m_dout = 8'h00; m_oe = 0;
    end else if (m_live) begin
      commit  = !m_wr_d && WR && !m_cs_d;
      dcommit = commit && m_ad_d;
      nx_dout = m_read(m_addr);
      nx_oe   = !CS && AD && !RD && WR;
      raw     = (m_cnt == T - 1);
      req     = raw || m_pend;
      m_cnt   = raw ? 0 : m_cnt + 1;
      if (commit && !m_ad_d) m_addr = m_din_d;
      if (dcommit) m_write(m_addr, m_din_d);
      else if (req) m_tick();
      m_pend = req && dcommit;
      m_wr_d = WR; m_cs_d = CS; m_ad_d = AD; m_din_d = data_in;
      m_dout = nx_dout; m_oe = nx_oe;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("dout", data_out, m_dout);
      chk("oe", {7'd0, data_oe}, {7'd0, m_oe});
      chk("irq", {7'd0, irq}, {7'd0, ~m_flag});
    end
  end

  task automatic bus_wr(input logic ad, input logic [7:0] v);
    @(negedge clk); CS = 0; AD = ad; RD = 1; WR = 0; data_in = v;
    @(negedge clk); WR = 1;
    @(negedge clk); CS = 1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] v);
    bus_wr(1'b0, a);
    bus_wr(1'b1, v);
  endtask

  task automatic reg_rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus_wr(1'b0, a);
    @(negedge clk); CS = 0; AD = 1; RD = 0; WR = 1;
    @(negedge clk);
    chk(name, data_out, exp);
    chk("rd_oe", {7'd0, data_oe}, 8'h01);
    RD = 1; CS = 1;
  endtask

  task automatic sync_to(input int k);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (m_cnt == k) return;
    end
    checks++; failures++;
    $display("FAIL sync_to prescaler phase %0d never reached", k);
  endtask

  // Data phase whose commit edge sees prescaler value k
  task automatic data_at_cnt(input int k, input logic [7:0] v);
    sync_to((k + T - 1) % T);
    CS = 0; AD = 1; RD = 1; WR = 0; data_in = v;
    @(negedge clk); WR = 1;
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 10))
      0: return 8'h00;  1: return 8'h21;  2: return 8'h22;  3: return 8'h23;
      4: return 8'h24;  5: return 8'h25;  6: return 8'h26;  7: return 8'h41;
      8: return 8'h42;  9: return 8'h43;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] gen_val(input logic [7:0] a);
    case (a)
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26: return b2d($urandom_range(0, 99));
      8'h41, 8'h42: return b2d($urandom_range(0, 59));
      8'h43:        return b2d($urandom_range(0, 23));
      default:      return 8'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_oe", {7'd0, data_oe}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h01);
    reset = 0;

    // write 0x45 to sec, read straight back before any tick can move it
    bus_wr(1'b0, 8'h21);
    data_at_cnt(0, 8'h45);
    @(negedge clk); RD = 0;
    @(negedge clk);
    chk("wr_rd_sec", data_out, 8'h45);
    chk("wr_rd_oe", {7'd0, data_oe}, 8'h01);
    RD = 1; CS = 1;

    // Feb 28, year 99, 23:59:59
    reg_wr(8'h21, 8'h00); reg_wr(8'h22, 8'h59); reg_wr(8'h23, 8'h23);
    reg_wr(8'h24, 8'h28); reg_wr(8'h25, 8'h02); reg_wr(8'h26, 8'h99);
    bus_wr(1'b0, 8'h21);
    data_at_cnt(0, 8'h59);
    @(negedge clk); CS = 1;
    repeat (4) @(negedge clk);
    chk("feb_sec", data_out, 8'h00);
    chk("feb_model_day", m_cal[3], 8'h01);
    chk("feb_model_month", m_cal[4], 8'h03);
    reg_rd_chk("feb_min", 8'h22, 8'h00);
    reg_rd_chk("feb_hour", 8'h23, 8'h00);
    reg_rd_chk("feb_day", 8'h24, 8'h01);
    reg_rd_chk("feb_month", 8'h25, 8'h03);
    reg_rd_chk("feb_year", 8'h26, 8'h99);

    // Dec 31, year 99, 23:59:59 rolls over to Jan 1, year 00
    reg_wr(8'h21, 8'h00); reg_wr(8'h22, 8'h59); reg_wr(8'h23, 8'h23);
    reg_wr(8'h24, 8'h31); reg_wr(8'h25, 8'h12); reg_wr(8'h26, 8'h99);
    bus_wr(1'b0, 8'h21);
    data_at_cnt(0, 8'h59);
    @(negedge clk); CS = 1;
    repeat (4) @(negedge clk);
    chk("ny_sec", data_out, 8'h00);
    chk("ny_model_year", m_cal[5], 8'h00);
    reg_rd_chk("ny_min", 8'h22, 8'h00);
    reg_rd_chk("ny_hour", 8'h23, 8'h00);
    reg_rd_chk("ny_day", 8'h24, 8'h01);
    reg_rd_chk("ny_month", 8'h25, 8'h01);
    reg_rd_chk("ny_year", 8'h26, 8'h00);

    // Countdown 00:00:02 raises irq; writing bit1=1 keeps it; writing 0 clears it
    reg_wr(8'h43, 8'h00); reg_wr(8'h42, 8'h00); reg_wr(8'h41, 8'h02);
    reg_wr(8'h00, 8'h01);
    repeat (12) @(negedge clk);
    chk("tmr_irq", {7'd0, irq}, 8'h00);
    chk("tmr_model_flag", {7'd0, m_flag}, 8'h01);
    reg_rd_chk("tmr_ctrl", 8'h00, 8'h02);
    reg_rd_chk("tmr_tsec", 8'h41, 8'h00);
    reg_wr(8'h00, 8'h02);
    chk("tmr_keep_irq", {7'd0, irq}, 8'h00);
    reg_wr(8'h00, 8'h00);
    chk("tmr_clr_irq", {7'd0, irq}, 8'h01);
    // enabling with the timer already at zero fires on the next tick
    reg_wr(8'h00, 8'h01);
    repeat (8) @(negedge clk);
    reg_rd_chk("tmr_zero_ctrl", 8'h00, 8'h02);
    reg_wr(8'h00, 8'h00);

    // commit coincident with a tick: written value first, then +1
    bus_wr(1'b0, 8'h21);
    data_at_cnt(T - 1, 8'h30);
    @(negedge clk); CS = 1;
    @(negedge clk);
    chk("coinc_written", data_out, 8'h30);
    @(negedge clk);
    chk("coinc_ticked", data_out, 8'h31);

    // reset in the middle of a data phase, WR rising right after release
    bus_wr(1'b0, 8'h21);
    @(negedge clk); CS = 0; AD = 1; RD = 1; WR = 0; data_in = 8'h77;
    @(negedge clk); reset = 1;
    @(negedge clk);
    chk("rstmid_dout", data_out, 8'h00);
    chk("rstmid_irq", {7'd0, irq}, 8'h01);
    reset = 0; WR = 1;
    @(negedge clk);
    chk("rstrel_dout", data_out, 8'h00);
    chk("rstrel_oe", {7'd0, data_oe}, 8'h00);
    chk("rstrel_model_addr", m_addr, 8'h00);
    CS = 1;
    reg_rd_chk("rstmid_ctrl", 8'h00, 8'h00);

    // random bus traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: bus_wr(1'b0, pick_addr());
        1, 2: bus_wr(1'b1, gen_val(m_addr));
        3: begin
          @(negedge clk); CS = 0; AD = 1; RD = 0; WR = 1;
          @(negedge clk); RD = 1; CS = 1;
        end
        4: begin
          @(negedge clk); CS = 1; AD = 1'($urandom); WR = 0; data_in = 8'($urandom);
          @(negedge clk); WR = 1;
        end
        5: begin
          @(negedge clk); CS = 1'($urandom); AD = 1'($urandom); RD = 1'($urandom);
          WR = 1; data_in = 8'($urandom);
          @(negedge clk); CS = 1; RD = 1;
        end
        6: repeat ($urandom_range(1, 6)) @(negedge clk);
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            @(negedge clk); reset = 1;
            @(negedge clk); reset = 0;
          end else begin
            @(negedge clk);
          end
        end
      endcase
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
